alu_rs: RTL and testbench

//  Reservation station directly upstream of the ALU. Buffers decoded ALU/branch ops from

---
 rtl/alu_rs_if.sv | 48 ++++
 rtl/alu_rs.sv | 179 +++++++++++++++++
 tb/tb_alu_rs.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Dispatch, CDB and ALU-issue signal bundle for the ALU reservation station.
// The slave side is the station itself; the master side is its environment.
interface alu_rs_if #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6
);
  logic              flush;
  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic              in_qj_busy;
  logic [ROB_W-1:0]  in_qj;
  logic [DATA_W-1:0] in_vj;
  logic              in_qk_busy;
  logic [ROB_W-1:0]  in_qk;
  logic [DATA_W-1:0] in_vk;
  logic [ROB_W-1:0]  in_rob_tag;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_imm;
  logic              full;
  logic              alu_cdb_v;
  logic [ROB_W-1:0]  alu_cdb_tag;
  logic [DATA_W-1:0] alu_cdb_data;
  logic              lsq_cdb_v;
  logic [ROB_W-1:0]  lsq_cdb_tag;
  logic [DATA_W-1:0] lsq_cdb_data;
  logic              alu_ena;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [ROB_W-1:0]  alu_rob_tag;
  logic [DATA_W-1:0] alu_pc;
  logic [DATA_W-1:0] alu_imm;

  modport master (
    output flush, in_valid, in_op, in_qj_busy, in_qj, in_vj, in_qk_busy, in_qk, in_vk,
           in_rob_tag, in_pc, in_imm,
           alu_cdb_v, alu_cdb_tag, alu_cdb_data, lsq_cdb_v, lsq_cdb_tag, lsq_cdb_data,
    input  full, alu_ena, alu_op, alu_a, alu_b, alu_rob_tag, alu_pc, alu_imm
  );

  modport slave (
    input  flush, in_valid, in_op, in_qj_busy, in_qj, in_vj, in_qk_busy, in_qk, in_vk,
           in_rob_tag, in_pc, in_imm,
           alu_cdb_v, alu_cdb_tag, alu_cdb_data, lsq_cdb_v, lsq_cdb_tag, lsq_cdb_data,
    output full, alu_ena, alu_op, alu_a, alu_b, alu_rob_tag, alu_pc, alu_imm
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, wakes operands from the ALU/LSQ
// result buses and issues the lowest-index ready entry to the ALU each cycle.
module alu_rs #(
  parameter int ENTRIES = 8,
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_rs_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0] busy_reg;
  logic [ENTRIES-1:0] qj_busy_reg;
  logic [ENTRIES-1:0] qk_busy_reg;
  logic [OP_W-1:0]    op_reg      [ENTRIES];
  logic [ROB_W-1:0]   qj_reg      [ENTRIES];
  logic [ROB_W-1:0]   qk_reg      [ENTRIES];
  logic [ROB_W-1:0]   rob_tag_reg [ENTRIES];
  logic [DATA_W-1:0]  vj_reg      [ENTRIES];
  logic [DATA_W-1:0]  vk_reg      [ENTRIES];
  logic [DATA_W-1:0]  pc_reg      [ENTRIES];
  logic [DATA_W-1:0]  imm_reg     [ENTRIES];

  logic               alu_ena_reg;
  logic [OP_W-1:0]    alu_op_reg;
  logic [DATA_W-1:0]  alu_a_reg;
  logic [DATA_W-1:0]  alu_b_reg;
  logic [ROB_W-1:0]   alu_rob_tag_reg;
  logic [DATA_W-1:0]  alu_pc_reg;
  logic [DATA_W-1:0]  alu_imm_reg;

  logic [ENTRIES-1:0] ready;
  logic [ENTRIES-1:0] j_alu_hit, j_lsq_hit, k_alu_hit, k_lsq_hit;
  logic [CNT_W-1:0]   busy_cnt;
  logic               full;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               push_en;
  logic               issue_en;
  logic               push_qj_busy_next, push_qk_busy_next;
  logic [DATA_W-1:0]  push_vj_next, push_vk_next;

  // Per-entry wakeup matches against both result buses, plus readiness.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign j_alu_hit[gi] = qj_busy_reg[gi] && bus.alu_cdb_v && (qj_reg[gi] == bus.alu_cdb_tag);
      assign j_lsq_hit[gi] = qj_busy_reg[gi] && bus.lsq_cdb_v && (qj_reg[gi] == bus.lsq_cdb_tag);
      assign k_alu_hit[gi] = qk_busy_reg[gi] && bus.alu_cdb_v && (qk_reg[gi] == bus.alu_cdb_tag);
      assign k_lsq_hit[gi] = qk_busy_reg[gi] && bus.lsq_cdb_v && (qk_reg[gi] == bus.lsq_cdb_tag);
      assign ready[gi]     = busy_reg[gi] && !qj_busy_reg[gi] && !qk_busy_reg[gi];
    end
  endgenerate

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy_reg[i]);
    end
  end

  assign full = (busy_cnt == CNT_W'(ENTRIES));

  // Downward scans so the lowest matching index is the one left standing.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_reg[i]) free_idx = IDX_W'(i);
      if (ready[i])     sel_idx  = IDX_W'(i);
    end
  end

  assign push_en  = bus.in_valid && !full && !bus.flush;
  assign issue_en = (|ready) && !bus.flush;

  // Operands broadcast in the dispatch cycle are captured directly; ALU bus wins a tie.
  always_comb begin
    push_qj_busy_next = bus.in_qj_busy;
    push_vj_next      = bus.in_vj;
    if (bus.in_qj_busy && bus.alu_cdb_v && (bus.alu_cdb_tag == bus.in_qj)) begin
      push_qj_busy_next = 1'b0;
      push_vj_next      = bus.alu_cdb_data;
    end else if (bus.in_qj_busy && bus.lsq_cdb_v && (bus.lsq_cdb_tag == bus.in_qj)) begin
      push_qj_busy_next = 1'b0;
      push_vj_next      = bus.lsq_cdb_data;
    end
    push_qk_busy_next = bus.in_qk_busy;
    push_vk_next      = bus.in_vk;
    if (bus.in_qk_busy && bus.alu_cdb_v && (bus.alu_cdb_tag == bus.in_qk)) begin
      push_qk_busy_next = 1'b0;
      push_vk_next      = bus.alu_cdb_data;
    end else if (bus.in_qk_busy && bus.lsq_cdb_v && (bus.lsq_cdb_tag == bus.in_qk)) begin
      push_qk_busy_next = 1'b0;
      push_vk_next      = bus.lsq_cdb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg        <= '0;
      qj_busy_reg     <= '0;
      qk_busy_reg     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_reg[i]      <= '0;
        qj_reg[i]      <= '0;
        qk_reg[i]      <= '0;
        rob_tag_reg[i] <= '0;
        vj_reg[i]      <= '0;
        vk_reg[i]      <= '0;
        pc_reg[i]      <= '0;
        imm_reg[i]     <= '0;
      end
      alu_ena_reg     <= 1'b0;
      alu_op_reg      <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_rob_tag_reg <= '0;
      alu_pc_reg      <= '0;
      alu_imm_reg     <= '0;
    end else if (bus.flush) begin
      busy_reg    <= '0;
      alu_ena_reg <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (j_alu_hit[i]) begin
          vj_reg[i]      <= bus.alu_cdb_data;
          qj_busy_reg[i] <= 1'b0;
        end else if (j_lsq_hit[i]) begin
          vj_reg[i]      <= bus.lsq_cdb_data;
          qj_busy_reg[i] <= 1'b0;
        end
        if (k_alu_hit[i]) begin
          vk_reg[i]      <= bus.alu_cdb_data;
          qk_busy_reg[i] <= 1'b0;
        end else if (k_lsq_hit[i]) begin
          vk_reg[i]      <= bus.lsq_cdb_data;
          qk_busy_reg[i] <= 1'b0;
        end
      end
      alu_ena_reg <= issue_en;
      if (issue_en) begin
        busy_reg[sel_idx] <= 1'b0;
        alu_op_reg        <= op_reg[sel_idx];
        alu_a_reg         <= vj_reg[sel_idx];
        alu_b_reg         <= vk_reg[sel_idx];
        alu_rob_tag_reg   <= rob_tag_reg[sel_idx];
        alu_pc_reg        <= pc_reg[sel_idx];
        alu_imm_reg       <= imm_reg[sel_idx];
      end
      // Placed last so a fresh push overrides any stale wakeup on the free slot.
      if (push_en) begin
        busy_reg[free_idx]    <= 1'b1;
        op_reg[free_idx]      <= bus.in_op;
        qj_busy_reg[free_idx] <= push_qj_busy_next;
        qj_reg[free_idx]      <= bus.in_qj;
        vj_reg[free_idx]      <= push_vj_next;
        qk_busy_reg[free_idx] <= push_qk_busy_next;
        qk_reg[free_idx]      <= bus.in_qk;
        vk_reg[free_idx]      <= push_vk_next;
        rob_tag_reg[free_idx] <= bus.in_rob_tag;
        pc_reg[free_idx]      <= bus.in_pc;
        imm_reg[free_idx]     <= bus.in_imm;
      end
    end
  end

  assign bus.full        = full;
  assign bus.alu_ena     = alu_ena_reg;
  assign bus.alu_op      = alu_op_reg;
  assign bus.alu_a       = alu_a_reg;
  assign bus.alu_b       = alu_b_reg;
  assign bus.alu_rob_tag = alu_rob_tag_reg;
  assign bus.alu_pc      = alu_pc_reg;
  assign bus.alu_imm     = alu_imm_reg;
endmodule

// File: tb/tb_alu_rs.sv
// Directed-vector bench for alu_rs: issue, wakeup, forwarding, full, priority,
// flush and asynchronous reset scenarios with hand-computed expectations.
module tb_alu_rs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  alu_rs_if #(.DATA_W(32), .ROB_W(4), .OP_W(6)) bus ();

  alu_rs #(.ENTRIES(8), .DATA_W(32), .ROB_W(4), .OP_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [5:0] op, input logic qjb, input logic [3:0] qj,
                          input logic [31:0] vj, input logic qkb, input logic [3:0] qk,
                          input logic [31:0] vk, input logic [3:0] tag);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_qj_busy = qjb;
    bus.in_qj      = qj;
    bus.in_vj      = vj;
    bus.in_qk_busy = qkb;
    bus.in_qk      = qk;
    bus.in_vk      = vk;
    bus.in_rob_tag = tag;
    bus.in_pc      = 32'h1000 + 32'(tag);
    bus.in_imm     = 32'h20 + 32'(tag);
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.alu_cdb_v = 1'b0;
    bus.lsq_cdb_v = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({bus.alu_ena, bus.full} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ena_full: got %b want 00", {bus.alu_ena, bus.full});
    end
    tests++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_rob_tag, bus.alu_pc, bus.alu_imm} !== '0) begin
      fails++;
      $display("FAIL reset_fields: op=%0h a=%0h b=%0h tag=%0h want all 0",
               bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_rob_tag);
    end
    #5 rst_n = 1'b1;
    tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_basic_issue();
    set_push(6'h01, 1'b0, 4'h0, 32'd3, 1'b0, 4'h0, 32'd4, 4'd2);
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.alu_ena !== 1'b0) begin
      fails++; $display("FAIL basic_early: alu_ena=%b want 0", bus.alu_ena);
    end
    tick();
    tests++;
    if ({bus.alu_ena, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_rob_tag} !== {1'b1, 6'h01, 32'd3, 32'd4, 4'd2}) begin
      fails++;
      $display("FAIL basic_issue: ena=%b op=%0h a=%0d b=%0d tag=%0d want 1 1 3 4 2",
               bus.alu_ena, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_rob_tag);
    end
    tests++;
    if ({bus.alu_pc, bus.alu_imm} !== {32'h1002, 32'h22}) begin
      fails++; $display("FAIL basic_pc_imm: pc=%0h imm=%0h want 1002 22", bus.alu_pc, bus.alu_imm);
    end
    tick();
    tests++;
    if ({bus.alu_ena, bus.alu_op, bus.alu_a} !== {1'b0, 6'h01, 32'd3}) begin
      fails++;
      $display("FAIL basic_pulse_hold: ena=%b op=%0h a=%0d want 0 1 3", bus.alu_ena, bus.alu_op, bus.alu_a);
    end
    $display("[TB] basic issue: op=%0h a=%0d b=%0d", bus.alu_op, bus.alu_a, bus.alu_b);
  endtask

  task automatic test_wakeup_alu();
    set_push(6'h02, 1'b1, 4'd5, 32'hdead, 1'b0, 4'h0, 32'd1, 4'd3);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.alu_ena !== 1'b0) begin
        fails++; $display("FAIL wake_pending_%0d: alu_ena=%b want 0", i, bus.alu_ena);
      end
      if (i < 2) tick();
    end
    bus.alu_cdb_v = 1'b1; bus.alu_cdb_tag = 4'd5; bus.alu_cdb_data = 32'd9;
    tick();
    bus.alu_cdb_v = 1'b0;
    tests++;
    if (bus.alu_ena !== 1'b0) begin
      fails++; $display("FAIL wake_latency: alu_ena=%b want 0 one cycle after wakeup", bus.alu_ena);
    end
    tick();
    tests++;
    if ({bus.alu_ena, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_rob_tag} !== {1'b1, 6'h02, 32'd9, 32'd1, 4'd3}) begin
      fails++;
      $display("FAIL wake_issue: ena=%b op=%0h a=%0d b=%0d tag=%0d want 1 2 9 1 3",
               bus.alu_ena, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_rob_tag);
    end
    tick();
    $display("[TB] alu wakeup: a=%0d", bus.alu_a);
  endtask

  task automatic test_push_forward();
    set_push(6'h03, 1'b0, 4'h0, 32'd7, 1'b1, 4'd7, 32'hbad, 4'd4);
    bus.lsq_cdb_v = 1'b1; bus.lsq_cdb_tag = 4'd7; bus.lsq_cdb_data = 32'h10;
    tick();
    bus.in_valid = 1'b0; bus.lsq_cdb_v = 1'b0;
    tests++;
    if (bus.alu_ena !== 1'b0) begin
      fails++; $display("FAIL fwd_early: alu_ena=%b want 0", bus.alu_ena);
    end
    tick();
    tests++;
    if ({bus.alu_ena, bus.alu_a, bus.alu_b, bus.alu_rob_tag} !== {1'b1, 32'd7, 32'h10, 4'd4}) begin
      fails++;
      $display("FAIL fwd_issue: ena=%b a=%0h b=%0h tag=%0d want 1 7 10 4",
               bus.alu_ena, bus.alu_a, bus.alu_b, bus.alu_rob_tag);
    end
    tick();
    $display("[TB] push forward: b=%0h", bus.alu_b);
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      set_push(6'h04, 1'b1, 4'(8 + i), 32'h0, 1'b0, 4'h0, 32'(i), 4'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    tests++;
    if (bus.full !== 1'b1) begin
      fails++; $display("FAIL full_set: full=%b want 1", bus.full);
    end
    set_push(6'h05, 1'b0, 4'h0, 32'h55, 1'b0, 4'h0, 32'h66, 4'd15);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tests++;
    if ({bus.alu_ena, bus.full} !== 2'b01) begin
      fails++; $display("FAIL full_ignore: ena,full=%b want 01", {bus.alu_ena, bus.full});
    end
    bus.alu_cdb_v = 1'b1; bus.alu_cdb_tag = 4'd11; bus.alu_cdb_data = 32'h33;
    tick();
    bus.alu_cdb_v = 1'b0;
    tick();
    tests++;
    if ({bus.alu_ena, bus.alu_a, bus.alu_b, bus.alu_rob_tag, bus.full} !== {1'b1, 32'h33, 32'd3, 4'd3, 1'b0}) begin
      fails++;
      $display("FAIL full_wake3: ena=%b a=%0h b=%0d tag=%0d full=%b want 1 33 3 3 0",
               bus.alu_ena, bus.alu_a, bus.alu_b, bus.alu_rob_tag, bus.full);
    end
    set_push(6'h06, 1'b0, 4'h0, 32'd1, 1'b0, 4'h0, 32'd2, 4'd9);
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.alu_ena, bus.full} !== 2'b01) begin
      fails++; $display("FAIL full_refill: ena,full=%b want 01", {bus.alu_ena, bus.full});
    end
    tick();
    tests++;
    if ({bus.alu_ena, bus.alu_op, bus.alu_rob_tag, bus.full} !== {1'b1, 6'h06, 4'd9, 1'b0}) begin
      fails++;
      $display("FAIL full_refill_issue: ena=%b op=%0h tag=%0d full=%b want 1 6 9 0",
               bus.alu_ena, bus.alu_op, bus.alu_rob_tag, bus.full);
    end
    do_flush();
    tests++;
    if (bus.full !== 1'b0) begin
      fails++; $display("FAIL full_cleanup: full=%b want 0", bus.full);
    end
    $display("[TB] full: refill issued tag=%0d", bus.alu_rob_tag);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      set_push(6'h08, 1'b1, 4'(i), 32'h0, 1'b0, 4'h0, 32'(i), 4'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    bus.alu_cdb_v = 1'b1; bus.alu_cdb_tag = 4'd1; bus.alu_cdb_data = 32'h11;
    bus.lsq_cdb_v = 1'b1; bus.lsq_cdb_tag = 4'd6; bus.lsq_cdb_data = 32'h66;
    tick();
    bus.alu_cdb_v = 1'b0; bus.lsq_cdb_v = 1'b0;
    tick();
    tests++;
    if ({bus.alu_ena, bus.alu_rob_tag, bus.alu_a, bus.alu_b} !== {1'b1, 4'd1, 32'h11, 32'd1}) begin
      fails++;
      $display("FAIL prio_first: ena=%b tag=%0d a=%0h b=%0d want 1 1 11 1",
               bus.alu_ena, bus.alu_rob_tag, bus.alu_a, bus.alu_b);
    end
    tick();
    tests++;
    if ({bus.alu_ena, bus.alu_rob_tag, bus.alu_a, bus.alu_b} !== {1'b1, 4'd6, 32'h66, 32'd6}) begin
      fails++;
      $display("FAIL prio_second: ena=%b tag=%0d a=%0h b=%0d want 1 6 66 6",
               bus.alu_ena, bus.alu_rob_tag, bus.alu_a, bus.alu_b);
    end
    tick();
    tests++;
    if (bus.alu_ena !== 1'b0) begin
      fails++; $display("FAIL prio_done: alu_ena=%b want 0", bus.alu_ena);
    end
    do_flush();
    $display("[TB] back to back: entries 1 then 6 issued");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      set_push(6'h09, 1'b1, 4'(12 + i), 32'h0, 1'b0, 4'h0, 32'h0, 4'(i));
      tick();
    end
    set_push(6'h0a, 1'b0, 4'h0, 32'd5, 1'b0, 4'h0, 32'd6, 4'd10);
    tick();
    set_push(6'h0b, 1'b0, 4'h0, 32'd7, 1'b0, 4'h0, 32'd8, 4'd11);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    tests++;
    if ({bus.alu_ena, bus.full} !== 2'b00) begin
      fails++; $display("FAIL flush_now: ena,full=%b want 00", {bus.alu_ena, bus.full});
    end
    bus.alu_cdb_v = 1'b1; bus.alu_cdb_tag = 4'd12; bus.alu_cdb_data = 32'h77;
    tick();
    bus.alu_cdb_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.alu_ena !== 1'b0) begin
        fails++; $display("FAIL flush_no_issue_%0d: alu_ena=%b tag=%0d want 0", i, bus.alu_ena, bus.alu_rob_tag);
      end
    end
    $display("[TB] flush: station emptied");
  endtask

  task automatic test_async_reset();
    set_push(6'h0c, 1'b0, 4'h0, 32'h44, 1'b0, 4'h0, 32'h45, 4'd13);
    tick();
    set_push(6'h0d, 1'b1, 4'd14, 32'h0, 1'b0, 4'h0, 32'h0, 4'd14);
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.alu_ena, bus.alu_a} !== {1'b1, 32'h44}) begin
      fails++; $display("FAIL areset_pre: ena=%b a=%0h want 1 44", bus.alu_ena, bus.alu_a);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.alu_ena, bus.full, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_rob_tag} !== '0) begin
      fails++;
      $display("FAIL areset_clear: ena=%b full=%b op=%0h a=%0h want all 0",
               bus.alu_ena, bus.full, bus.alu_op, bus.alu_a);
    end
    #1 rst_n = 1'b1;
    bus.alu_cdb_v = 1'b1; bus.alu_cdb_tag = 4'd14; bus.alu_cdb_data = 32'h99;
    tick();
    bus.alu_cdb_v = 1'b0;
    tick();
    tests++;
    if (bus.alu_ena !== 1'b0) begin
      fails++; $display("FAIL areset_empty: alu_ena=%b want 0 after reset", bus.alu_ena);
    end
    $display("[TB] async reset: outputs cleared");
  endtask

  initial begin
    idle_inputs();
    bus.in_op = '0; bus.in_qj_busy = 1'b0; bus.in_qj = '0; bus.in_vj = '0;
    bus.in_qk_busy = 1'b0; bus.in_qk = '0; bus.in_vk = '0; bus.in_rob_tag = '0;
    bus.in_pc = '0; bus.in_imm = '0;
    bus.alu_cdb_tag = '0; bus.alu_cdb_data = '0; bus.lsq_cdb_tag = '0; bus.lsq_cdb_data = '0;
    test_reset();
    test_basic_issue();
    test_wakeup_alu();
    test_push_forward();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
